s3g_tx_arbiter: RTL and testbench

//  Shares one s3g_tx packet transmitter between NREQ packet sources, such as command replies and

---
 rtl/s3g_pkg.sv | 15 +
 rtl/s3g_tx_arbiter_rr_pick.sv | 30 +++
 rtl/s3g_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_s3g_tx_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/s3g_pkg.sv
// Shared definitions for the s3g transmit path: arbiter state encoding and framing constants.
package s3g_pkg;

  localparam int         S3G_MAXLEN = 16;
  localparam logic [7:0] S3G_SYNC   = 8'hD5;

  typedef enum logic [2:0] {
    ARB_IDLE       = 3'd0,
    ARB_SELECT     = 3'd1,
    ARB_ISSUE      = 3'd2,
    ARB_WAIT_START = 3'd3,
    ARB_WAIT_END   = 3'd4
  } arb_state_e;

endpackage

// File: rtl/s3g_tx_arbiter_rr_pick.sv
// Round-robin priority picker: first set request at or above ptr, else lowest set request.
module rr_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic         valid,
  output logic [2:0]   idx
);

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!valid && req[i] && (3'(i) >= ptr)) begin
        valid = 1'b1;
        idx   = 3'(i);
      end
    end
    // Nothing at or above the pointer: wrap around to the lowest requester.
    for (int i = 0; i < N; i++) begin
      if (!valid && req[i]) begin
        valid = 1'b1;
        idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/s3g_tx_arbiter.sv
// Shares one s3g_tx transmitter between NREQ packet sources: source 0 has strict priority,
// the rest are served round-robin; one packet in flight, acked when tx_busy falls.
module s3g_tx_arbiter
  import s3g_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int MAXLEN   = S3G_MAXLEN,
  parameter int BUSY_TMO = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   req_len,
  input  logic [128*NREQ-1:0] req_buf,
  output logic [NREQ-1:0]     req_ack,
  output logic [NREQ-1:0]     req_err,
  output logic                tx_packet_wr,
  output logic [7:0]          tx_payload_len,
  output logic [127:0]        tx_buf,
  input  logic                tx_busy,
  output logic [2:0]          grant_id,
  output logic                arb_busy
);

  arb_state_e      state, state_nxt;
  logic [2:0]      rr_ptr;
  logic [7:0]      tmo_cnt;
  logic            busy_q;
  logic [NREQ-1:0] rr_req;
  logic            pick_valid;
  logic [2:0]      pick_idx;
  logic            win_valid;
  logic [2:0]      winner;
  logic [7:0]      win_len;
  logic [127:0]    win_buf;
  logic            len_bad;
  logic            tmo_hit;
  logic            busy_fall;

  // Source 0 bypasses the rotation, so it is masked out of the round-robin picker.
  assign rr_req = {req[NREQ-1:1], 1'b0};

  rr_pick #(.N(NREQ)) u_rr_pick (
    .req   (rr_req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign win_valid = req[0] | pick_valid;
  assign winner    = req[0] ? 3'd0 : pick_idx;

  always_comb begin
    win_len = '0;
    win_buf = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (3'(i) == winner) begin
        win_len = req_len[8*i +: 8];
        win_buf = req_buf[128*i +: 128];
      end
    end
  end

  assign len_bad   = win_valid && (win_len > 8'(MAXLEN));
  assign tmo_hit   = (tmo_cnt == 8'(BUSY_TMO));
  assign busy_fall = busy_q & ~tx_busy;

  // NOTE: async reset with non-blocking assignments; every register here has a defined reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_IDLE:       if ((|req) && !tx_busy) state_nxt = ARB_SELECT;
      ARB_SELECT:     state_nxt = (!win_valid || len_bad) ? ARB_IDLE : ARB_ISSUE;
      ARB_ISSUE:      state_nxt = ARB_WAIT_START;
      ARB_WAIT_START: begin
        if (tx_busy)      state_nxt = ARB_WAIT_END;
        else if (tmo_hit) state_nxt = ARB_IDLE;
      end
      ARB_WAIT_END:   if (busy_fall) state_nxt = ARB_IDLE;
      default:        state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    arb_busy     = (state != ARB_IDLE);
    tx_packet_wr = (state == ARB_ISSUE);
    req_ack      = '0;
    req_err      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (state == ARB_SELECT && len_bad && 3'(i) == winner)
        req_err[i] = 1'b1;
      if (state == ARB_WAIT_START && !tx_busy && tmo_hit && 3'(i) == grant_id)
        req_err[i] = 1'b1;
      if (state == ARB_WAIT_END && busy_fall && 3'(i) == grant_id)
        req_ack[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id       <= '0;
      tx_payload_len <= '0;
      tx_buf         <= '0;
      tmo_cnt        <= '0;
      busy_q         <= 1'b0;
      rr_ptr         <= 3'd1;
    end else begin
      busy_q <= tx_busy;
      // Captured once per grant and held until the next SELECT, so s3g_tx sees stable data.
      if (state == ARB_SELECT && win_valid) begin
        grant_id       <= winner;
        tx_payload_len <= win_len;
        tx_buf         <= win_buf;
      end
      if (state == ARB_ISSUE)
        tmo_cnt <= '0;
      else if (state == ARB_WAIT_START && !tmo_hit)
        tmo_cnt <= tmo_cnt + 8'd1;
      if (state == ARB_WAIT_END && busy_fall && grant_id != 3'd0)
        rr_ptr <= (grant_id >= 3'(NREQ-1)) ? 3'd1 : grant_id + 3'd1;
    end
  end

endmodule

// File: tb/tb_s3g_tx_arbiter.sv
// Directed bench for s3g_tx_arbiter with a simple s3g_tx busy model.
module tb_s3g_tx_arbiter;

  localparam int NREQ = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req = '0;
  logic [8*NREQ-1:0]   req_len = '0;
  logic [128*NREQ-1:0] req_buf = '0;
  logic [NREQ-1:0]     req_ack, req_err;
  logic                tx_packet_wr;
  logic [7:0]          tx_payload_len;
  logic [127:0]        tx_buf;
  logic                tx_busy;
  logic [2:0]          grant_id;
  logic                arb_busy;

  int passed = 0;
  int total  = 0;

  s3g_tx_arbiter #(.NREQ(NREQ), .MAXLEN(16), .BUSY_TMO(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_len        (req_len),
    .req_buf        (req_buf),
    .req_ack        (req_ack),
    .req_err        (req_err),
    .tx_packet_wr   (tx_packet_wr),
    .tx_payload_len (tx_payload_len),
    .tx_buf         (tx_buf),
    .tx_busy        (tx_busy),
    .grant_id       (grant_id),
    .arb_busy       (arb_busy)
  );

  always #5 clk = ~clk;

  // s3g_tx model: busy rises the cycle after packet_wr and lasts sync+len+payload+crc cycles.
  logic         tx_dead = 1'b0;
  int           mcnt;
  logic [7:0]   cap_len;
  logic [127:0] cap_buf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy <= 1'b0;
      mcnt    <= 0;
      cap_len <= '0;
      cap_buf <= '0;
    end else if (tx_packet_wr && !tx_dead) begin
      tx_busy <= 1'b1;
      mcnt    <= int'(tx_payload_len) + 3;
      cap_len <= tx_payload_len;
      cap_buf <= tx_buf;
    end else if (mcnt > 1) begin
      mcnt <= mcnt - 1;
    end else begin
      mcnt    <= 0;
      tx_busy <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  typedef struct {
    logic [2:0] req;
    logic [7:0] l0, l1, l2;
    logic [2:0] grant;
    logic [2:0] ack;
    logic [2:0] err;
    int         pw;
    logic [7:0] len;
  } vec_t;

  vec_t tbl[11];

  task automatic run_row(input int i);
    int n;
    int pw;
    logic [2:0] a, e;
    req_len = {tbl[i].l2, tbl[i].l1, tbl[i].l0};
    req     = tbl[i].req;
    pw = 0;
    a  = '0;
    e  = '0;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (tx_packet_wr) pw++;
      if ((|req_ack) || (|req_err)) begin
        a = req_ack;
        e = req_err;
        break;
      end
    end
    check($sformatf("row%0d_done", i), 128'(n < 100), 128'(1));
    check($sformatf("row%0d_grant", i), 128'(grant_id), 128'(tbl[i].grant));
    check($sformatf("row%0d_ack", i), 128'(a), 128'(tbl[i].ack));
    check($sformatf("row%0d_err", i), 128'(e), 128'(tbl[i].err));
    check($sformatf("row%0d_pw", i), 128'(pw), 128'(tbl[i].pw));
    if (tbl[i].pw > 0)
      check($sformatf("row%0d_len", i), 128'(cap_len), 128'(tbl[i].len));
  endtask

  initial begin
    int n;
    int m;
    logic [2:0] e;
    logic [2:0] a;

    // Source payloads: src0 A0.., src1 11,22,33.., src2 51..
    for (int k = 0; k < 16; k++) begin
      req_buf[8*k +: 8]       = 8'hA0 + 8'(k);
      req_buf[128 + 8*k +: 8] = 8'(8'h11 * (k + 1));
      req_buf[256 + 8*k +: 8] = 8'h51 + 8'(k);
    end

    //            req     l0     l1     l2     grant  ack     err     pw len
    tbl[0]  = '{3'b010, 8'd2, 8'd3, 8'd5,  3'd1, 3'b010, 3'b000, 1, 8'd3};
    tbl[1]  = '{3'b101, 8'd2, 8'd3, 8'd5,  3'd0, 3'b001, 3'b000, 1, 8'd2};
    tbl[2]  = '{3'b100, 8'd2, 8'd3, 8'd5,  3'd2, 3'b100, 3'b000, 1, 8'd5};
    tbl[3]  = '{3'b110, 8'd2, 8'd3, 8'd5,  3'd1, 3'b010, 3'b000, 1, 8'd3};
    tbl[4]  = '{3'b110, 8'd2, 8'd3, 8'd5,  3'd2, 3'b100, 3'b000, 1, 8'd5};
    tbl[5]  = '{3'b110, 8'd2, 8'd3, 8'd5,  3'd1, 3'b010, 3'b000, 1, 8'd3};
    tbl[6]  = '{3'b110, 8'd2, 8'd3, 8'd5,  3'd2, 3'b100, 3'b000, 1, 8'd5};
    tbl[7]  = '{3'b100, 8'd2, 8'd3, 8'd17, 3'd2, 3'b000, 3'b100, 0, 8'd0};
    tbl[8]  = '{3'b001, 8'd0, 8'd3, 8'd5,  3'd0, 3'b001, 3'b000, 1, 8'd0};
    tbl[9]  = '{3'b110, 8'd2, 8'd3, 8'd5,  3'd1, 3'b010, 3'b000, 1, 8'd3};
    tbl[10] = '{3'b110, 8'd2, 8'd3, 8'd5,  3'd1, 3'b010, 3'b000, 1, 8'd3};

    // Reset values
    #1;
    check("rst_ctrl", 128'({arb_busy, tx_packet_wr, req_ack, req_err, grant_id}), 128'(0));
    check("rst_len", 128'(tx_payload_len), 128'(0));
    check("rst_buf", tx_buf, 128'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_row(i);
      if (i == 0) begin
        check("frame_byte0", 128'(cap_buf[7:0]), 128'(8'h11));
        check("frame_byte1", 128'(cap_buf[15:8]), 128'(8'h22));
        check("frame_byte2", 128'(cap_buf[23:16]), 128'(8'h33));
      end
    end
    req = '0;
    repeat (3) @(negedge clk);
    check("idle_after_table", 128'(arb_busy), 128'(0));

    // Latency and timeout with a transmitter that never goes busy
    tx_dead = 1'b1;
    req = 3'b010;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (tx_packet_wr) break;
    end
    check("latency_cycles", 128'(n), 128'(2));
    e = '0;
    a = '0;
    for (m = 1; m <= 20; m++) begin
      @(negedge clk);
      a = a | req_ack;
      if (|req_err) begin
        e = req_err;
        break;
      end
    end
    check("tmo_cycles", 128'(m), 128'(5));
    check("tmo_err", 128'(e), 128'(3'b010));
    check("tmo_no_ack", 128'(a), 128'(0));
    req = '0;
    @(negedge clk);
    check("tmo_idle", 128'(arb_busy), 128'(0));
    tx_dead = 1'b0;
    @(negedge clk);

    // Reset during WAIT_END
    req_len = {8'd5, 8'd3, 8'd2};
    req = 3'b010;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (tx_busy) break;
    end
    @(negedge clk);
    check("pre_rst_busy", 128'({arb_busy, tx_busy}), 128'(2'b11));
    #1 rst = 1'b1;
    #1;
    check("midrst_ctrl", 128'({arb_busy, tx_packet_wr, req_ack, req_err, grant_id}), 128'(0));
    check("midrst_len", 128'(tx_payload_len), 128'(0));
    check("midrst_buf", tx_buf, 128'(0));
    req = '0;
    a = '0;
    repeat (2) begin
      @(negedge clk);
      a = a | req_ack | req_err;
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      a = a | req_ack | req_err;
    end
    check("midrst_no_resp", 128'(a), 128'(0));

    // After reset the round-robin pointer is back at 1
    run_row(10);
    req = '0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
